// File: rtl/interboard_tx.sv
// -----------------------------------------------------------------------------
// interboard_tx
//   Transmit stage of the interboard link. Game-master control messages are
//   buffered in a small FIFO, split into two 6-bit beats and moved to the peer
//   board with a four-phase Request_out / Ack_in handshake. A per-phase timeout
//   abandons the current message if the peer stops answering.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   ctrl_en        in   one-cycle enqueue strobe
//   ctrl_msg_type  in   [2:0] message type, sampled with ctrl_en
//   ctrl_number    in   [4:0] number payload, sampled with ctrl_en
//   Ack_in         in   peer acknowledge (asynchronous to clk)
//   inter_ready    out  FIFO not full (combinational from occupancy)
//   Request_out    out  request to the peer (registered)
//   inter_data_out out  [5:0] beat data to the peer (registered)
//   tx_busy        out  FSM active or FIFO holding messages (registered)
//   tx_drop        out  one-cycle pulse: strobe arrived while FIFO full
//   tx_timeout     out  sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module interboard_tx #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_en,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    input  logic       Ack_in,
    output logic       inter_ready,
    output logic       Request_out,
    output logic [5:0] inter_data_out,
    output logic       tx_busy,
    output logic       tx_drop,
    output logic       tx_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SETUP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW:0]   CNT_ZERO   = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] SETUP_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] SETUP_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_ZERO  = {TW{1'b0}};
    localparam logic [TW-1:0] TOUT_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_REQ_HI  = 3'd2,
        ST_REQ_LO  = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // First beat carries the type; bit 5 low marks it as the leading beat.
    function automatic logic [5:0] enc_beat0(input logic [2:0] msg_type);
        return {3'b000, msg_type};
    endfunction

    // Second beat carries the number; bit 5 high marks it as the trailing beat.
    function automatic logic [5:0] enc_beat1(input logic [4:0] number);
        return {1'b1, number};
    endfunction

    state_t          state_r;
    state_t          state_s;

    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [AW:0]     count_nxt_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic [7:0]      head_s;

    logic            ack_meta_r;
    logic            ack_sync_r;

    logic [4:0]      num_r;
    logic            beat_r;
    logic [CW-1:0]   setup_cnt_r;
    logic [TW-1:0]   tout_cnt_r;
    logic            request_r;
    logic [5:0]      data_r;
    logic            busy_r;
    logic            drop_r;
    logic            timeout_r;

    logic [4:0]      num_nxt_s;
    logic            beat_nxt_s;
    logic [CW-1:0]   setup_nxt_s;
    logic [TW-1:0]   tout_nxt_s;
    logic            req_nxt_s;
    logic [5:0]      data_nxt_s;
    logic            tmo_nxt_s;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never
    // rescues a strobe that arrives while full.
    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);
    assign push_s  = ctrl_en && !full_s;
    assign pop_s   = (state_r == ST_IDLE) && !empty_s;
    assign head_s  = mem_r[rd_ptr_r];

    assign inter_ready    = !full_s;
    assign Request_out    = request_r;
    assign inter_data_out = data_r;
    assign tx_busy        = busy_r;
    assign tx_drop        = drop_r;
    assign tx_timeout     = timeout_r;

    // Occupancy after this edge, used for the count register and tx_busy.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO storage and pointers; power-of-two depth gives natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {ctrl_msg_type, ctrl_number};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Two-flop synchroniser for the asynchronous peer acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_meta_r <= 1'b0;
            ack_sync_r <= 1'b0;
        end else begin
            ack_meta_r <= Ack_in;
            ack_sync_r <= ack_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) state_s = ST_SETUP;
                else          state_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (setup_cnt_r == SETUP_LAST) state_s = ST_REQ_HI;
                else                           state_s = ST_SETUP;
            end
            ST_REQ_HI: begin
                if (ack_sync_r)                    state_s = ST_REQ_LO;
                else if (tout_cnt_r == TOUT_LAST)  state_s = ST_RECOVER;
                else                               state_s = ST_REQ_HI;
            end
            ST_REQ_LO: begin
                if (!ack_sync_r)                   state_s = beat_r ? ST_IDLE : ST_SETUP;
                else if (tout_cnt_r == TOUT_LAST)  state_s = ST_RECOVER;
                else                               state_s = ST_REQ_LO;
            end
            ST_RECOVER: begin
                if (!ack_sync_r) state_s = ST_IDLE;
                else             state_s = ST_RECOVER;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered handshake datapath.
    always_comb begin
        num_nxt_s   = num_r;
        beat_nxt_s  = beat_r;
        setup_nxt_s = setup_cnt_r;
        tout_nxt_s  = tout_cnt_r;
        req_nxt_s   = request_r;
        data_nxt_s  = data_r;
        tmo_nxt_s   = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    num_nxt_s   = head_s[4:0];
                    data_nxt_s  = enc_beat0(head_s[7:5]);
                    beat_nxt_s  = 1'b0;
                    setup_nxt_s = SETUP_ZERO;
                end else begin
                    num_nxt_s   = num_r;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_r == SETUP_LAST) begin
                    req_nxt_s  = 1'b1;
                    tout_nxt_s = TOUT_ZERO;
                end else begin
                    setup_nxt_s = setup_cnt_r + SETUP_ONE;
                end
            end
            ST_REQ_HI: begin
                if (ack_sync_r) begin
                    req_nxt_s  = 1'b0;
                    tout_nxt_s = TOUT_ZERO;
                end else if (tout_cnt_r == TOUT_LAST) begin
                    req_nxt_s = 1'b0;
                    tmo_nxt_s = 1'b1;
                end else begin
                    tout_nxt_s = tout_cnt_r + TOUT_ONE;
                end
            end
            ST_REQ_LO: begin
                if (!ack_sync_r) begin
                    // After the trailing beat the data lines simply hold.
                    if (!beat_r) begin
                        data_nxt_s  = enc_beat1(num_r);
                        beat_nxt_s  = 1'b1;
                        setup_nxt_s = SETUP_ZERO;
                    end else begin
                        data_nxt_s  = data_r;
                    end
                end else if (tout_cnt_r == TOUT_LAST) begin
                    req_nxt_s = 1'b0;
                    tmo_nxt_s = 1'b1;
                end else begin
                    tout_nxt_s = tout_cnt_r + TOUT_ONE;
                end
            end
            ST_RECOVER: begin
                req_nxt_s = 1'b0;
            end
            default: begin
                req_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake datapath and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_r       <= 5'd0;
            beat_r      <= 1'b0;
            setup_cnt_r <= SETUP_ZERO;
            tout_cnt_r  <= TOUT_ZERO;
            request_r   <= 1'b0;
            data_r      <= 6'd0;
            busy_r      <= 1'b0;
            drop_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            num_r       <= num_nxt_s;
            beat_r      <= beat_nxt_s;
            setup_cnt_r <= setup_nxt_s;
            tout_cnt_r  <= tout_nxt_s;
            request_r   <= req_nxt_s;
            data_r      <= data_nxt_s;
            busy_r      <= (state_s != ST_IDLE) || (count_nxt_s != CNT_ZERO);
            drop_r      <= ctrl_en && full_s;
            timeout_r   <= tmo_nxt_s;
        end
    end

endmodule

// File: tb/tb_interboard_tx.sv
// -----------------------------------------------------------------------------
// tb_interboard_tx
//   Directed bench for interboard_tx (FIFO_DEPTH=4, SETUP_CYCLES=2,
//   TIMEOUT_CYCLES=50). Inputs are driven and outputs sampled on the falling
//   edge; the DUT captures on the rising edge.
// -----------------------------------------------------------------------------
module tb_interboard_tx;

    logic       clk;
    logic       rst;
    logic       ctrl_en;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic       Ack_in;
    logic       inter_ready;
    logic       Request_out;
    logic [5:0] inter_data_out;
    logic       tx_busy;
    logic       tx_drop;
    logic       tx_timeout;

    int checks = 0;
    int errors = 0;

    interboard_tx #(
        .FIFO_DEPTH    (4),
        .SETUP_CYCLES  (2),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_en       (ctrl_en),
        .ctrl_msg_type (ctrl_msg_type),
        .ctrl_number   (ctrl_number),
        .Ack_in        (Ack_in),
        .inter_ready   (inter_ready),
        .Request_out   (Request_out),
        .inter_data_out(inter_data_out),
        .tx_busy       (tx_busy),
        .tx_drop       (tx_drop),
        .tx_timeout    (tx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enqueue one message; returns on the falling edge after the sampling edge.
    task automatic push_msg(input logic [2:0] t, input logic [4:0] n);
        ctrl_en       = 1'b1;
        ctrl_msg_type = t;
        ctrl_number   = n;
        @(negedge clk);
        ctrl_en       = 1'b0;
    endtask

    // Wait (bounded) for Request_out to reach a level, then check it.
    task automatic wait_req(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (Request_out !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, Request_out}, {31'd0, lvl});
    endtask

    // Act as a well-behaved peer for one beat, acknowledging 3 cycles late.
    task automatic do_beat(input logic [5:0] exp, input string tag);
        wait_req(1'b1, 60, {tag, "_req_rise"});
        chk({tag, "_data_hi"}, {26'd0, inter_data_out}, {26'd0, exp});
        repeat (3) @(negedge clk);
        Ack_in = 1'b1;
        wait_req(1'b0, 60, {tag, "_req_fall"});
        chk({tag, "_data_lo"}, {26'd0, inter_data_out}, {26'd0, exp});
        repeat (3) @(negedge clk);
        Ack_in = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        ctrl_en       = 1'b0;
        ctrl_msg_type = 3'd0;
        ctrl_number   = 5'd0;
        Ack_in        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req",     {31'd0, Request_out}, 32'd0);
        chk("rst_data",    {26'd0, inter_data_out}, 32'd0);
        chk("rst_ready",   {31'd0, inter_ready}, 32'd1);
        chk("rst_busy",    {31'd0, tx_busy}, 32'd0);
        chk("rst_drop",    {31'd0, tx_drop}, 32'd0);
        chk("rst_timeout", {31'd0, tx_timeout}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single message: type 2, number 17 -> beats 02, 31
        push_msg(3'd2, 5'd17);
        chk("single_req_t0", {31'd0, Request_out}, 32'd0);
        @(negedge clk);
        chk("single_data_t1", {26'd0, inter_data_out}, 32'h02);
        chk("single_req_t1",  {31'd0, Request_out}, 32'd0);
        @(negedge clk);
        chk("single_req_t2",  {31'd0, Request_out}, 32'd0);
        @(negedge clk);
        chk("single_req_t3",  {31'd0, Request_out}, 32'd1);
        do_beat(6'h02, "single_b0");
        do_beat(6'h31, "single_b1");
        repeat (2) @(negedge clk);
        chk("single_busy_before", {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
        chk("single_busy_after",  {31'd0, tx_busy}, 32'd0);

        // Simultaneous push/pop: second strobe lands as the first is popped
        push_msg(3'd3, 5'd21);
        push_msg(3'd2, 5'd8);
        chk("pp_data",  {26'd0, inter_data_out}, 32'h03);
        chk("pp_ready", {31'd0, inter_ready}, 32'd1);
        chk("pp_busy",  {31'd0, tx_busy}, 32'd1);
        do_beat(6'h03, "pp_a0");
        do_beat(6'h35, "pp_a1");
        do_beat(6'h02, "pp_b0");
        do_beat(6'h28, "pp_b1");
        repeat (4) @(negedge clk);
        chk("pp_idle", {31'd0, tx_busy}, 32'd0);

        // Back-to-back: peer stalls on m0 while 5 strobes arrive
        push_msg(3'd6, 5'd9);
        wait_req(1'b1, 20, "b2b_m0_req");
        push_msg(3'd1, 5'd3);
        push_msg(3'd4, 5'd10);
        push_msg(3'd7, 5'd31);
        chk("b2b_ready_3", {31'd0, inter_ready}, 32'd1);
        push_msg(3'd0, 5'd0);
        chk("b2b_ready_4", {31'd0, inter_ready}, 32'd0);
        chk("b2b_nodrop",  {31'd0, tx_drop}, 32'd0);
        push_msg(3'd5, 5'd5);
        chk("b2b_drop",    {31'd0, tx_drop}, 32'd1);
        chk("b2b_full",    {31'd0, inter_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_drop_end", {31'd0, tx_drop}, 32'd0);
        do_beat(6'h06, "b2b_m0_b0");
        do_beat(6'h29, "b2b_m0_b1");
        do_beat(6'h01, "b2b_s1_b0");
        do_beat(6'h23, "b2b_s1_b1");
        do_beat(6'h04, "b2b_s2_b0");
        do_beat(6'h2A, "b2b_s2_b1");
        do_beat(6'h07, "b2b_s3_b0");
        do_beat(6'h3F, "b2b_s3_b1");
        do_beat(6'h00, "b2b_s4_b0");
        do_beat(6'h20, "b2b_s4_b1");
        repeat (20) @(negedge clk);
        chk("b2b_no_fifth_req",  {31'd0, Request_out}, 32'd0);
        chk("b2b_no_fifth_busy", {31'd0, tx_busy}, 32'd0);
        chk("b2b_no_timeout",    {31'd0, tx_timeout}, 32'd0);

        // Timeout: peer silent on c, d queued behind it
        push_msg(3'd1, 5'd1);
        push_msg(3'd4, 5'd2);
        wait_req(1'b1, 20, "tmo_req_rise");
        chk("tmo_data", {26'd0, inter_data_out}, 32'h01);
        repeat (49) @(negedge clk);
        chk("tmo_req_49", {31'd0, Request_out}, 32'd1);
        chk("tmo_flag_49", {31'd0, tx_timeout}, 32'd0);
        @(negedge clk);
        chk("tmo_req_50",  {31'd0, Request_out}, 32'd0);
        chk("tmo_flag_50", {31'd0, tx_timeout}, 32'd1);
        do_beat(6'h04, "tmo_d_b0");
        do_beat(6'h22, "tmo_d_b1");
        repeat (4) @(negedge clk);
        chk("tmo_sticky", {31'd0, tx_timeout}, 32'd1);
        chk("tmo_idle",   {31'd0, tx_busy}, 32'd0);

        // Stuck-high ack: e times out in the ack-fall wait, f queued
        push_msg(3'd5, 5'd6);
        push_msg(3'd6, 5'd12);
        wait_req(1'b1, 20, "stk_req_rise");
        chk("stk_data", {26'd0, inter_data_out}, 32'h05);
        repeat (3) @(negedge clk);
        Ack_in = 1'b1;
        wait_req(1'b0, 20, "stk_req_fall");
        repeat (60) @(negedge clk);
        chk("stk_recover_req",  {31'd0, Request_out}, 32'd0);
        chk("stk_recover_data", {26'd0, inter_data_out}, 32'h05);
        chk("stk_recover_busy", {31'd0, tx_busy}, 32'd1);
        Ack_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("stk_release_hold", {26'd0, inter_data_out}, 32'h05);
        @(negedge clk);
        chk("stk_release_pop",  {26'd0, inter_data_out}, 32'h06);
        do_beat(6'h06, "stk_f_b0");
        do_beat(6'h2C, "stk_f_b1");
        repeat (4) @(negedge clk);

        // Reset mid-beat: g in REQ_HI, h and i queued
        push_msg(3'd1, 5'd2);
        push_msg(3'd2, 5'd3);
        push_msg(3'd3, 5'd4);
        wait_req(1'b1, 20, "mid_req_rise");
        rst = 1'b0;
        #1;
        chk("mid_rst_req",     {31'd0, Request_out}, 32'd0);
        chk("mid_rst_data",    {26'd0, inter_data_out}, 32'd0);
        chk("mid_rst_ready",   {31'd0, inter_ready}, 32'd1);
        chk("mid_rst_timeout", {31'd0, tx_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_post_req",  {31'd0, Request_out}, 32'd0);
        chk("mid_post_busy", {31'd0, tx_busy}, 32'd0);
        chk("mid_post_data", {26'd0, inter_data_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
